cram_ld_ctrl: RTL
=================

# cram_ld_ctrl

Load-sequence controller for the CRAM. It accepts a load command stream (Acq token, two ID words, R-Config attribute, length/stride/base words) from the upstream link and forwards the IDs downstream. It then issues one CRAM read request per word and marks the read data stream with Acq on the first word and Rls on the last, under downstream Nack back-pressure. It is the read-side counterpart of the CRAM store controller and sits between the CRAM address unit / RAM macro and the outgoing link.

## Interface
- WIDTH_LENGTH, 8, width of the access-length count
- NumWordsLength, 1, link words carrying the length field
- NumWordsStride, 1, link words carrying the stride field
- NumWordsBase, 1, link words carrying the base field

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- I_Valid  in  1  upstream word valid
- is_Acq  in  1  upstream word is Acq token
- is_Rls  in  1  upstream Rls token; aborts an active load
- is_RConfigData  in  1  attribute word is R-Config
- I_Length  in  WIDTH_LENGTH  configured length; stable from aCTIVE entry
- I_Nack  in  1  downstream stall
- O_Nack  out  1  upstream stall; high in aCTIVE_LD and dRAIN_LD
- O_SendIDs  out  1  emit stored ID word downstream
- O_IDNo  out  2  ID select: 1 = T-ID, 2 = F-ID
- O_Set_ConfigData, O_We_Length, O_We_Stride, O_We_Base  out  1  config register write-enables
- O_Req  out  1  CRAM read request; address unit advances on it
- O_Valid  out  1  downstream read data valid
- O_Sel_Hold  out  1  data mux selects the hold register, not RAM output
- O_We_Hold  out  1  capture RAM output into the hold register
- O_Acq  out  1  with O_Valid: first data word
- O_Rls  out  1  with O_Valid: last data word; alone: abort release
- O_Trm  out  1  one-cycle termination pulse

## Operation
- Core FSM states: iNIT_LD, sEND_T_ID, sEND_F_ID, gET_ATTRIB_LD, gET_CONFIG_LD, aCTIVE_LD, dRAIN_LD.
- iNIT_LD -> sEND_T_ID on I_Valid & is_Acq.
- sEND_T_ID and sEND_F_ID each hold until ~I_Nack. In each, O_SendIDs = ~I_Nack and O_IDNo = 1 or 2. They then advance to sEND_F_ID and gET_ATTRIB_LD respectively.
- gET_ATTRIB_LD -> gET_CONFIG_LD on I_Valid & is_RConfigData. A valid non-config word is ignored.
- Config sub-FSM: iNIT, sET_CONFIG, sET_LENGTH, sET_STRIDE. It uses a word counter R_NumWords, reset to 1 at each field start, incremented on I_Valid, and saturating at the field's NumWords. O_Set_ConfigData pulses on the first valid word. Each We_* pulses when I_Valid and the counter equals the field size. The last base word moves the core to aCTIVE_LD.
- aCTIVE_LD:
  - Counter R_Cnt is cleared on entry.
  - O_Req = ~I_Nack & ~R_HoldFull & (R_Cnt < I_Length); R_Cnt increments on O_Req.
  - When R_Cnt == I_Length and nothing is in flight, go to iNIT_LD and pulse O_Trm.
- Read latency is one cycle. R_Flight is registered O_Req.
- If R_Flight & I_Nack: assert O_We_Hold and set R_HoldFull.
- While R_HoldFull: O_Sel_Hold = 1, O_Valid = ~I_Nack. R_HoldFull clears when the word is accepted.
- Otherwise O_Valid = R_Flight & ~I_Nack.
- O_Acq is asserted with the accepted word of index 0. O_Rls is asserted with the accepted word of index I_Length-1. Word index is tracked by R_OutCnt.
- I_Length = 0: no requests. One cycle after entry, pulse O_Trm and O_Rls without O_Valid, then go to iNIT_LD.
- is_Rls in aCTIVE_LD:
  - Stop new requests and go to dRAIN_LD.
  - Deliver the in-flight or held word without O_Rls.
  - Then pulse O_Rls and O_Trm together without O_Valid, and go to iNIT_LD.
- is_Rls in iNIT_LD is ignored.

## Timing
- Reset: all outputs 0, all FSMs in their init state, all counters 0. Reset asserted mid-load aborts immediately; no O_Trm is issued.
- O_Req at cycle t gives O_Valid at t+1 unless I_Nack is high at t+1.
- Throughput is one word per cycle with I_Nack low. At most one word is buffered, so the hold register never overflows.
- Simultaneous events:
  - is_Rls and the last O_Req in the same cycle: Rls has priority and the word is delivered without O_Rls.
  - I_Nack during sEND_*: the ID is re-sent in the next cycle.
- Counters are WIDTH_LENGTH+1 bits, so I_Length = 2^WIDTH_LENGTH-1 does not wrap.

## Structure
- Add to pkg_mem:
  - fsm_ldcore enum (core FSM states)
  - fsm_sendids enum (ID-send states)
  - the existing fsm_config_st enum, reused for the config sub-FSM
- Sub-module cram_ld_cfg_seq: the config sub-FSM and the O_We_* generation, parameterised by the three NumWords values.

## Test plan
- Acq, then R-Config, then length 4 (stride 1, base 0), I_Nack low -> O_SendIDs with IDNo 1 then 2; O_Req for 4 cycles; O_Valid for 4 cycles with Acq on word 0 and Rls on word 3; O_Trm one cycle later.
- Same command with I_Nack high for one cycle after the second O_Req -> O_We_Hold pulses once, O_Sel_Hold for one accepted word, exactly 4 words delivered in order.
- Length 0 -> no O_Req, no O_Valid; O_Rls and O_Trm for one cycle; FSM back in iNIT_LD.
- is_Rls after 2 of 8 requests -> 2 words delivered, no O_Rls on data; then one O_Rls+O_Trm cycle; no further O_Req.
- NumWordsLength=2, NumWordsStride=1, NumWordsBase=2 -> O_We_Length on the 2nd length word, O_We_Stride on the 3rd config word, O_We_Base on the 5th.
- reset driven to 0 mid-stream (cycle 3 of an 8-word load) -> all outputs 0 asynchronously; after release, a fresh Acq sequence completes normally.

Source files
------------

// File: rtl/cram_ld_ctrl_pkg.sv
// Shared state encodings and constants for the CRAM load controller.
package cram_ld_ctrl_pkg;

  typedef enum logic [2:0] {
    iNIT_LD,
    sEND_T_ID,
    sEND_F_ID,
    gET_ATTRIB_LD,
    gET_CONFIG_LD,
    aCTIVE_LD,
    dRAIN_LD
  } fsm_ldcore;

  // Doubles as the O_IDNo encoding.
  typedef enum logic [1:0] {
    ID_NONE = 2'd0,
    ID_T    = 2'd1,
    ID_F    = 2'd2
  } fsm_sendids;

  typedef enum logic [1:0] {
    iNIT,
    sET_CONFIG,
    sET_LENGTH,
    sET_STRIDE
  } fsm_config_st;

  localparam int unsigned CFG_CNT_W = 8;

endpackage

// File: rtl/cram_ld_ctrl_if.sv
// Upstream command link, downstream stall and CRAM-side control signals of the load controller.
interface cram_ld_ctrl_if #(
  parameter int unsigned WIDTH_LENGTH = 8
);
  logic                    I_Valid;
  logic                    is_Acq;
  logic                    is_Rls;
  logic                    is_RConfigData;
  logic [WIDTH_LENGTH-1:0] I_Length;
  logic                    I_Nack;

  logic                    O_Nack;
  logic                    O_SendIDs;
  logic [1:0]              O_IDNo;
  logic                    O_Set_ConfigData;
  logic                    O_We_Length;
  logic                    O_We_Stride;
  logic                    O_We_Base;
  logic                    O_Req;
  logic                    O_Valid;
  logic                    O_Sel_Hold;
  logic                    O_We_Hold;
  logic                    O_Acq;
  logic                    O_Rls;
  logic                    O_Trm;

  // master: link/RAM environment; slave: the controller
  modport master (
    output I_Valid, is_Acq, is_Rls, is_RConfigData, I_Length, I_Nack,
    input  O_Nack, O_SendIDs, O_IDNo, O_Set_ConfigData, O_We_Length, O_We_Stride,
           O_We_Base, O_Req, O_Valid, O_Sel_Hold, O_We_Hold, O_Acq, O_Rls, O_Trm
  );

  modport slave (
    input  I_Valid, is_Acq, is_Rls, is_RConfigData, I_Length, I_Nack,
    output O_Nack, O_SendIDs, O_IDNo, O_Set_ConfigData, O_We_Length, O_We_Stride,
           O_We_Base, O_Req, O_Valid, O_Sel_Hold, O_We_Hold, O_Acq, O_Rls, O_Trm
  );
endinterface

// File: rtl/cram_ld_ctrl_cfg_seq.sv
// Config sub-FSM: walks attribute, length, stride and base words and pulses the register write-enables.
module cram_ld_cfg_seq
  import cram_ld_ctrl_pkg::*;
#(
  parameter int unsigned NumWordsLength = 1,
  parameter int unsigned NumWordsStride = 1,
  parameter int unsigned NumWordsBase   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic valid_i,
  output logic set_config_o,
  output logic we_length_o,
  output logic we_stride_o,
  output logic we_base_o,
  output logic done_o
);

  localparam logic [CFG_CNT_W-1:0] N_LEN = CFG_CNT_W'(NumWordsLength);
  localparam logic [CFG_CNT_W-1:0] N_STR = CFG_CNT_W'(NumWordsStride);
  localparam logic [CFG_CNT_W-1:0] N_BAS = CFG_CNT_W'(NumWordsBase);

  fsm_config_st         state_q, state_d;
  logic [CFG_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    set_config_o = 1'b0;
    we_length_o  = 1'b0;
    we_stride_o  = 1'b0;
    we_base_o    = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      iNIT: if (start_i) begin
        set_config_o = 1'b1;
        state_d      = sET_CONFIG;
        cnt_d        = CFG_CNT_W'(1);
      end
      sET_CONFIG: if (valid_i) begin
        if (cnt_q == N_LEN) begin
          we_length_o = 1'b1;
          state_d     = sET_LENGTH;
          cnt_d       = CFG_CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CFG_CNT_W'(1);
        end
      end
      sET_LENGTH: if (valid_i) begin
        if (cnt_q == N_STR) begin
          we_stride_o = 1'b1;
          state_d     = sET_STRIDE;
          cnt_d       = CFG_CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CFG_CNT_W'(1);
        end
      end
      sET_STRIDE: if (valid_i) begin
        if (cnt_q == N_BAS) begin
          we_base_o = 1'b1;
          done_o    = 1'b1;
          state_d   = iNIT;
        end else begin
          cnt_d = cnt_q + CFG_CNT_W'(1);
        end
      end
      default: state_d = iNIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= iNIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/cram_ld_ctrl.sv
// CRAM load-sequence controller: takes a load command, forwards IDs, then streams CRAM reads with
// Acq/Rls framing under downstream back-pressure, using a one-word hold register.
module cram_ld_ctrl
  import cram_ld_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH_LENGTH   = 8,
  parameter int unsigned NumWordsLength = 1,
  parameter int unsigned NumWordsStride = 1,
  parameter int unsigned NumWordsBase   = 1
) (
  input logic           clock,
  input logic           reset,
  cram_ld_ctrl_if.slave bus
);

  localparam int unsigned CW = WIDTH_LENGTH + 1;

  fsm_ldcore     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, outcnt_q, outcnt_d;
  logic          flight_q, hold_q, hold_d;
  logic [CW-1:0] len;
  logic          pipe_empty, cfg_start, cfg_done;
  fsm_sendids    id_no;
  logic          send_ids, req, valid, sel_hold, we_hold, acq, rls, trm, nack;

  assign len        = {1'b0, bus.I_Length};
  assign pipe_empty = ~flight_q & ~hold_q;

  cram_ld_cfg_seq #(
    .NumWordsLength(NumWordsLength),
    .NumWordsStride(NumWordsStride),
    .NumWordsBase  (NumWordsBase)
  ) u_cfg (
    .clk         (clock),
    .rst_n       (reset),
    .start_i     (cfg_start),
    .valid_i     (bus.I_Valid),
    .set_config_o(bus.O_Set_ConfigData),
    .we_length_o (bus.O_We_Length),
    .we_stride_o (bus.O_We_Stride),
    .we_base_o   (bus.O_We_Base),
    .done_o      (cfg_done)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    outcnt_d  = outcnt_q;
    hold_d    = hold_q;
    cfg_start = 1'b0;
    id_no     = ID_NONE;
    send_ids  = 1'b0;
    req       = 1'b0;
    valid     = 1'b0;
    sel_hold  = 1'b0;
    we_hold   = 1'b0;
    acq       = 1'b0;
    rls       = 1'b0;
    trm       = 1'b0;
    nack      = 1'b0;

    // Read-data path; flight/hold are only ever set in aCTIVE_LD/dRAIN_LD.
    if (hold_q) begin
      sel_hold = 1'b1;
      valid    = ~bus.I_Nack;
      if (!bus.I_Nack) hold_d = 1'b0;
    end else if (flight_q) begin
      valid = ~bus.I_Nack;
      if (bus.I_Nack) begin
        we_hold = 1'b1;
        hold_d  = 1'b1;
      end
    end
    if (valid) outcnt_d = outcnt_q + CW'(1);

    case (state_q)
      iNIT_LD: if (bus.I_Valid && bus.is_Acq) state_d = sEND_T_ID;
      sEND_T_ID: begin
        id_no    = ID_T;
        send_ids = ~bus.I_Nack;
        if (!bus.I_Nack) state_d = sEND_F_ID;
      end
      sEND_F_ID: begin
        id_no    = ID_F;
        send_ids = ~bus.I_Nack;
        if (!bus.I_Nack) state_d = gET_ATTRIB_LD;
      end
      gET_ATTRIB_LD: if (bus.I_Valid && bus.is_RConfigData) begin
        cfg_start = 1'b1;
        state_d   = gET_CONFIG_LD;
      end
      gET_CONFIG_LD: if (cfg_done) begin
        state_d  = aCTIVE_LD;
        cnt_d    = '0;
        outcnt_d = '0;
      end
      aCTIVE_LD: begin
        nack = 1'b1;
        acq  = valid && (outcnt_q == '0);
        if (cnt_q == len && pipe_empty) begin
          trm     = 1'b1;
          rls     = (len == '0);
          state_d = iNIT_LD;
        end else if (bus.is_Rls) begin
          // Abort wins over any request this cycle; data in flight loses its Rls marker.
          state_d = dRAIN_LD;
        end else begin
          rls = valid && (outcnt_q == len - CW'(1));
          req = ~bus.I_Nack && ~hold_q && (cnt_q < len);
          if (req) cnt_d = cnt_q + CW'(1);
        end
      end
      dRAIN_LD: begin
        nack = 1'b1;
        acq  = valid && (outcnt_q == '0);
        if (pipe_empty) begin
          rls     = 1'b1;
          trm     = 1'b1;
          state_d = iNIT_LD;
        end
      end
      default: state_d = iNIT_LD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= iNIT_LD;
      cnt_q    <= '0;
      outcnt_q <= '0;
      flight_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      outcnt_q <= outcnt_d;
      flight_q <= req;
      hold_q   <= hold_d;
    end
  end

  assign bus.O_Nack     = nack;
  assign bus.O_SendIDs  = send_ids;
  assign bus.O_IDNo     = id_no;
  assign bus.O_Req      = req;
  assign bus.O_Valid    = valid;
  assign bus.O_Sel_Hold = sel_hold;
  assign bus.O_We_Hold  = we_hold;
  assign bus.O_Acq      = acq;
  assign bus.O_Rls      = rls;
  assign bus.O_Trm      = trm;

endmodule
